// File: rtl/sincronizador_desrebote.sv
// Synchronizer plus counter-based debounce for raw front-panel pins; optional DEBOUNCE_INVERT_EN inverts the pin (active-low buttons).
// Latency: output follows a stable pin change after SYNC_STAGES+DEBOUNCE_CYCLES clk edges; no backpressure, level output only.
module sincronizador_desrebote #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada_asincronica,
    output logic entrada_sincronica_desrebotada,
    output logic ocupado
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_UNO    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               DIRECTO    = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        ESTABLE_BAJO     = 2'b00,
        CONFIRMANDO_ALTO = 2'b01,
        ESTABLE_ALTO     = 2'b10,
        CONFIRMANDO_BAJO = 2'b11
    } estado_t;

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    logic                   entrada_pin;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sinc;
    estado_t                estado_q;
    estado_t                estado_nxt;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   salida_q;
    logic                   salida_nxt;
    logic                   ocupado_q;
    logic                   ocupado_nxt;

`ifdef DEBOUNCE_INVERT_EN
    assign entrada_pin = ~entrada_asincronica;
`else
    assign entrada_pin = entrada_asincronica;
`endif

    assign sinc = sync_q[SYNC_STAGES-1];

    // Plain shift chain: any logic between stages would defeat metastability settling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], entrada_pin};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= ESTABLE_BAJO;
            cnt_q     <= '0;
            salida_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_nxt;
            cnt_q     <= cnt_nxt;
            salida_q  <= salida_nxt;
            ocupado_q <= ocupado_nxt;
        end
    end

    // cnt_q counts edges already seen differing; the edge that completes the run flips the state.
    always_comb begin
        estado_nxt = estado_q;
        cnt_nxt    = cnt_q;
        case (estado_q)
            ESTABLE_BAJO: begin
                if (sinc) begin
                    if (DIRECTO) begin
                        estado_nxt = ESTABLE_ALTO;
                        cnt_nxt    = '0;
                    end else begin
                        estado_nxt = CONFIRMANDO_ALTO;
                        cnt_nxt    = CNT_UNO;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            CONFIRMANDO_ALTO: begin
                if (!sinc) begin
                    estado_nxt = ESTABLE_BAJO;
                    cnt_nxt    = '0;
                end else if (cnt_q == CNT_ULTIMO) begin
                    estado_nxt = ESTABLE_ALTO;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_UNO;
                end
            end
            ESTABLE_ALTO: begin
                if (!sinc) begin
                    if (DIRECTO) begin
                        estado_nxt = ESTABLE_BAJO;
                        cnt_nxt    = '0;
                    end else begin
                        estado_nxt = CONFIRMANDO_BAJO;
                        cnt_nxt    = CNT_UNO;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            CONFIRMANDO_BAJO: begin
                if (sinc) begin
                    estado_nxt = ESTABLE_ALTO;
                    cnt_nxt    = '0;
                end else if (cnt_q == CNT_ULTIMO) begin
                    estado_nxt = ESTABLE_BAJO;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_UNO;
                end
            end
            default: begin
                estado_nxt = ESTABLE_BAJO;
                cnt_nxt    = '0;
            end
        endcase
    end

    // Decoded from the next state so both outputs come straight off flops.
    always_comb begin
        salida_nxt  = 1'b0;
        ocupado_nxt = 1'b0;
        case (estado_nxt)
            ESTABLE_BAJO: begin
                salida_nxt  = 1'b0;
                ocupado_nxt = 1'b0;
            end
            CONFIRMANDO_ALTO: begin
                salida_nxt  = 1'b0;
                ocupado_nxt = 1'b1;
            end
            ESTABLE_ALTO: begin
                salida_nxt  = 1'b1;
                ocupado_nxt = 1'b0;
            end
            CONFIRMANDO_BAJO: begin
                salida_nxt  = 1'b1;
                ocupado_nxt = 1'b1;
            end
            default: begin
                salida_nxt  = 1'b0;
                ocupado_nxt = 1'b0;
            end
        endcase
    end

    assign entrada_sincronica_desrebotada = salida_q;
    assign ocupado                        = ocupado_q;

endmodule

// File: tb/tb_sincronizador_desrebote.sv
// Bench for sincronizador_desrebote with SYNC_STAGES=2, DEBOUNCE_CYCLES=4: vector table, corner sequences, random runs vs. model.
module tb_sincronizador_desrebote;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic reset;
    logic entrada;
    logic salida;
    logic ocupado;

    int n_total = 0;
    int n_pass  = 0;

    sincronizador_desrebote #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk                           (clk),
        .reset                         (reset),
        .entrada_asincronica           (entrada),
        .entrada_sincronica_desrebotada(salida),
        .ocupado                       (ocupado)
    );

    always #5 clk = ~clk;

    // Reference model: output flips once the last DEB samples seen by the debouncer all differ from it.
    bit raw_h[$];
    bit sinc_h[$];
    bit m_out;
    bit m_ocu;

    task automatic model_reset();
        raw_h.delete();
        sinc_h.delete();
        m_out = 1'b0;
        m_ocu = 1'b0;
    endtask

    task automatic model_step(input bit raw);
        bit s;
        bit all_diff;
        s = (raw_h.size() >= SYNC) ? raw_h[raw_h.size() - SYNC] : 1'b0;
        raw_h.push_back(raw);
        sinc_h.push_back(s);
        if (raw_h.size() > 16) void'(raw_h.pop_front());
        if (sinc_h.size() > 16) void'(sinc_h.pop_front());
        all_diff = (sinc_h.size() >= DEB);
        for (int k = 0; k < DEB && all_diff; k++) begin
            if (sinc_h[sinc_h.size() - 1 - k] == m_out) all_diff = 1'b0;
        end
        if (all_diff) begin
            m_out = ~m_out;
            m_ocu = 1'b0;
        end else begin
            m_ocu = (s != m_out);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic edge_step(input bit raw);
        entrada = raw;
        @(posedge clk);
        model_step(raw);
        #1;
    endtask

    task automatic do_reset(input bit raw);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        entrada = raw;
        reset   = 1'b0;
    endtask

    typedef struct packed {
        bit rst;
        bit raw;
        bit out;
        bit ocu;
    } vec_t;

    vec_t tabla[$];

    task automatic add(input bit rst, input bit raw, input bit out, input bit ocu);
        vec_t v;
        v.rst = rst; v.raw = raw; v.out = out; v.ocu = ocu;
        tabla.push_back(v);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int rise;
        int run_left;
        bit cur;
        bit bounce[6];

        reset   = 1'b1;
        entrada = 1'b0;
        model_reset();
        #2;
        chk("reset_out", salida, 0);
        chk("reset_ocu", ocupado, 0);

        // Rise held high; then fall held low; then a 3-cycle pulse that must be rejected.
        add(1, 1, 0, 0); add(0, 1, 0, 0); add(0, 1, 0, 1); add(0, 1, 0, 1);
        add(0, 1, 0, 1); add(0, 1, 1, 0); add(0, 1, 1, 0);
        add(0, 0, 1, 0); add(0, 0, 1, 0); add(0, 0, 1, 1); add(0, 0, 1, 1);
        add(0, 0, 1, 1); add(0, 0, 0, 0); add(0, 0, 0, 0);
        add(1, 1, 0, 0); add(0, 1, 0, 0); add(0, 1, 0, 1); add(0, 0, 0, 1);
        add(0, 0, 0, 1); add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0);

        for (int i = 0; i < tabla.size(); i++) begin
            if (tabla[i].rst) do_reset(tabla[i].raw);
            edge_step(tabla[i].raw);
            chk($sformatf("vec%0d_out", i), salida, tabla[i].out);
            chk($sformatf("vec%0d_ocu", i), ocupado, tabla[i].ocu);
        end

        // Async reset between edges with output high.
        do_reset(1'b1);
        repeat (7) edge_step(1'b1);
        chk("t1_pre_out", salida, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("t1_async_out", salida, 0);
        chk("t1_async_ocu", ocupado, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("t1_hold_out", salida, 0);
            chk("t1_hold_ocu", ocupado, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Bounce train: last 0->1 lands before edge 6, so output must first rise after edge 11.
        do_reset(1'b1);
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rise = -1;
        for (int e = 1; e <= 20; e++) begin
            edge_step(e <= 6 ? bounce[e-1] : 1'b1);
            if (rise < 0 && salida === 1'b1) rise = e;
        end
        chk("t4_rise_edge", rise, 11);
        chk("t4_ocu_idle", ocupado, 0);

        // Reset during confirmation (counter at 2) discards the partial count.
        do_reset(1'b1);
        repeat (4) edge_step(1'b1);
        chk("t6_pre_ocu", ocupado, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_ocu", ocupado, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        rise = -1;
        for (int e = 1; e <= 15; e++) begin
            edge_step(1'b1);
            if (rise < 0 && salida === 1'b1) rise = e;
        end
        chk("t6_rise_edge", rise, 6);

        // Random runs of 1..8 cycles against the model.
        do_reset(1'b0);
        run_left = 0;
        cur = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (run_left == 0) begin
                cur      = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 8);
            end
            edge_step(cur);
            run_left--;
            chk("rand_out", salida, m_out);
            chk("rand_ocu", ocupado, m_ocu);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
